// File: rtl/ihs_pkg.sv
// Shared definitions for the instruction handshake sequencer: opcodes,
// feeder state encoding and instruction width.
package ihs_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program memory: 2**ADDR_W words, one write port, registered read port.
module prog_mem
  import ihs_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic               clock,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [2**ADDR_W];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Synchronous read of the address presented this cycle.
  always_ff @(posedge clock) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: steps through program memory, presenting one word on
// iin at a time and advancing only when the processor pulses done. Stops on
// the halt opcode, at the last memory word, or when the watchdog expires.
//
// Handshake: run=1 means iin holds an instruction the processor must
// execute; the processor answers with a single-cycle done pulse, which is
// only honoured while run=1. After done, run drops for exactly one cycle
// (ISSUE) while the next word is fetched.
module instr_feeder
  import ihs_pkg::*;
#(
  parameter int         ADDR_W  = 4,
  parameter int         TIMEOUT = 16,
  parameter logic [2:0] HALT_OP = OP_HALT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic               done,
  output logic [INSTR_W-1:0] iin,
  output logic               run,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               timeout,
  output feeder_state_t      state
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [ADDR_W-1:0] PC_LAST  = '1;

  logic [CNT_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0]  next_pc;
  logic [INSTR_W-1:0] rd_data;
  logic               mem_we;

  // Writes are blocked while a program is in flight.
  assign mem_we = prog_we & ~busy;

  // Next pc also drives the memory read address, so the word for the
  // upcoming ISSUE cycle is already on rd_data when ISSUE begins.
  always_comb begin
    next_pc = pc;
    case (state)
      ST_IDLE, ST_HALT, ST_FAULT: if (start) next_pc = '0;
      ST_WAIT: if (done && pc != PC_LAST) next_pc = pc + ADDR_W'(1);
      default: next_pc = pc;
    endcase
  end

  prog_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (next_pc),
    .rdata (rd_data)
  );

  // Sequencer FSM with registered handshake/status outputs and watchdog.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= '0;
      iin      <= '0;
      run      <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      timeout  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      pc <= next_pc;
      case (state)
        ST_IDLE, ST_HALT, ST_FAULT: begin
          if (start) begin
            state    <= ST_ISSUE;
            busy     <= 1'b1;
            halted   <= 1'b0;
            timeout  <= 1'b0;
            wait_cnt <= '0;
          end
        end
        ST_ISSUE: begin
          iin      <= rd_data;
          wait_cnt <= '0;
          if (rd_data[15:13] == HALT_OP) begin
            state  <= ST_HALT;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else begin
            state <= ST_WAIT;
            run   <= 1'b1;
          end
        end
        ST_WAIT: begin
          // done takes priority over an expiring watchdog in the same cycle
          if (done) begin
            run      <= 1'b0;
            wait_cnt <= '0;
            if (pc == PC_LAST) begin
              state  <= ST_HALT;
              halted <= 1'b1;
              busy   <= 1'b0;
            end else begin
              state <= ST_ISSUE;
            end
          end else if (wait_cnt >= CNT_LAST) begin
            state   <= ST_FAULT;
            run     <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          run   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: a small processor model answers run with done
// after a programmable delay; a monitor checks every issued {pc, iin}
// against an expected queue filled by the stimulus.
module tb_instr_feeder;
  import ihs_pkg::*;

  localparam int AW = 4;

  logic          clock;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          start;
  logic          done;
  logic [15:0]   iin;
  logic          run;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          timeout;
  feeder_state_t state;

  instr_feeder #(.ADDR_W(AW), .TIMEOUT(16), .HALT_OP(OP_HALT)) dut (
    .clock     (clock),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .done      (done),
    .iin       (iin),
    .run       (run),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .timeout   (timeout),
    .state     (state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [AW+15:0] exp_q[$];

  bit proc_en  = 1'b0;
  int proc_dly = 3;
  int run_cnt  = 0;
  logic run_q  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // processor model: done pulse proc_dly cycles after run rises
  always @(negedge clock) begin
    if (proc_en && run) begin
      run_cnt++;
      done = (run_cnt == proc_dly);
    end else begin
      run_cnt = 0;
      if (proc_en) done = 1'b0;
    end
  end

  // monitor: every run rise is one issued instruction
  always @(negedge clock) begin
    if (run && !run_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue unexpected pc=%0d iin=%h", pc, iin);
      end else begin
        logic [AW+15:0] e;
        e = exp_q.pop_front();
        if ({pc, iin} !== e) begin
          errors++;
          $display("FAIL issue actual pc=%0d iin=%h required pc=%0d iin=%h",
                   pc, iin, e[AW+15:16], e[15:0]);
        end
      end
    end
    run_q = run;
  end

  // driver tasks
  task automatic write_word(input int a, input logic [15:0] d);
    @(negedge clock);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    @(negedge clock);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic expect_normal(input logic [15:0] w1);
    exp_q.push_back({4'd0, 16'hA01C});
    exp_q.push_back({4'd1, w1});
    exp_q.push_back({4'd2, 16'h2080});
    exp_q.push_back({4'd3, 16'h8000});
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(halted || timeout) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("end_reached", 32'(n < budget), 32'd1);
  endtask

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; done = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_run", 32'(run), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_iin", 32'(iin), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    reset = 1'b0;

    // stray done in IDLE
    @(negedge clock); done = 1'b1;
    @(negedge clock); done = 1'b0;
    check("stray_state", 32'(state), 32'(ST_IDLE));
    check("stray_busy", 32'(busy), 0);
    check("stray_pc", 32'(pc), 0);

    // normal program, with a write attempted while busy
    write_word(0, 16'hA01C);
    write_word(1, 16'hA40A);
    write_word(2, 16'h2080);
    write_word(3, 16'h8000);
    write_word(4, 16'hE000);
    proc_en = 1'b1; proc_dly = 3;
    expect_normal(16'hA40A);
    pulse_start();
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 16'h0000;
    @(negedge clock);
    prog_we = 1'b0;
    wait_end(200);
    check("norm_halted", 32'(halted), 1);
    check("norm_run", 32'(run), 0);
    check("norm_busy", 32'(busy), 0);
    check("norm_pc", 32'(pc), 4);
    check("norm_iin", 32'(iin), 32'hE000);
    check("norm_timeout", 32'(timeout), 0);
    check("norm_q_empty", 32'(exp_q.size()), 0);

    // write accepted in HALT and seen on the next run
    write_word(1, 16'h0000);
    expect_normal(16'h0000);
    pulse_start();
    check("rerun_halted_clr", 32'(halted), 0);
    wait_end(200);
    check("wr_halted", 32'(halted), 1);
    check("wr_q_empty", 32'(exp_q.size()), 0);

    // asynchronous reset in WAIT at pc=2
    write_word(1, 16'hA40A);
    exp_q.push_back({4'd0, 16'hA01C});
    exp_q.push_back({4'd1, 16'hA40A});
    exp_q.push_back({4'd2, 16'h2080});
    pulse_start();
    begin
      int n = 0;
      while (!(run && pc == 4'd2) && n < 100) begin
        @(negedge clock);
        n++;
      end
      check("pc2_reached", 32'(n < 100), 1);
    end
    #2 reset = 1'b1;
    #1;
    check("arst_run", 32'(run), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_pc", 32'(pc), 0);
    check("arst_iin", 32'(iin), 0);
    check("arst_state", 32'(state), 32'(ST_IDLE));
    @(negedge clock);
    reset = 1'b0;
    check("arst_q_empty", 32'(exp_q.size()), 0);
    expect_normal(16'hA40A);
    pulse_start();
    wait_end(200);
    check("arst_rerun_halted", 32'(halted), 1);
    check("arst_rerun_pc", 32'(pc), 4);

    // done on the last permitted WAIT cycle wins over the watchdog
    proc_dly = 16;
    expect_normal(16'hA40A);
    pulse_start();
    wait_end(400);
    check("corner_timeout", 32'(timeout), 0);
    check("corner_halted", 32'(halted), 1);
    check("corner_q_empty", 32'(exp_q.size()), 0);

    // watchdog: no done at all
    proc_en = 1'b0; done = 1'b0;
    exp_q.push_back({4'd0, 16'hA01C});
    pulse_start();
    begin
      int k = 0;
      int n = 0;
      while (!timeout && k < 60) begin
        if (run) n++;
        @(negedge clock);
        k++;
      end
      check("wd_run_cycles", 32'(n), 16);
    end
    check("wd_timeout", 32'(timeout), 1);
    check("wd_run", 32'(run), 0);
    check("wd_busy", 32'(busy), 0);
    check("wd_pc", 32'(pc), 0);
    check("wd_state", 32'(state), 32'(ST_FAULT));
    exp_q.push_back({4'd0, 16'hA01C});
    pulse_start();
    check("wd_clear", 32'(timeout), 0);
    wait_end(60);
    check("wd_again", 32'(timeout), 1);

    // end of memory: all words non-halt, no wrap
    for (int i = 0; i < 16; i++) begin
      write_word(i, 16'h8000);
      exp_q.push_back({4'(i), 16'h8000});
    end
    proc_en = 1'b1; proc_dly = 1;
    pulse_start();
    wait_end(300);
    check("eom_halted", 32'(halted), 1);
    check("eom_pc", 32'(pc), 15);
    check("eom_timeout", 32'(timeout), 0);
    check("eom_iin", 32'(iin), 32'h8000);
    check("eom_q_empty", 32'(exp_q.size()), 0);

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
